// File: rtl/adiv5_wait_retry_pkg.sv
// ============================================================================
// adiv5_wait_retry_pkg : shared widths, stat codes and FSM encoding
// Revision 1.0
// ============================================================================
`default_nettype none

package adiv5_wait_retry_pkg;

   localparam int ADIv5_CMD_WIDTH  = 36;
   localparam int ADIv5_RESP_WIDTH = 35;

   localparam logic [2:0] ADIv5_STAT_OK    = 3'b001;
   localparam logic [2:0] ADIv5_STAT_WAIT  = 3'b010;
   localparam logic [2:0] ADIv5_STAT_FAULT = 3'b100;

   typedef logic [2:0] retry_state_t;

   localparam retry_state_t ST_IDLE      = 3'd0;
   localparam retry_state_t ST_ISSUE     = 3'd1;
   localparam retry_state_t ST_WAIT_RESP = 3'd2;
   localparam retry_state_t ST_CAPTURE   = 3'd3;
   localparam retry_state_t ST_BACKOFF   = 3'd4;

   typedef enum logic [1:0] {
      STAT_CLS_OK,
      STAT_CLS_WAIT,
      STAT_CLS_FAULT
   } stat_class_t;

   // Unknown stat encodings are deliberately folded into FAULT.
   function automatic stat_class_t stat_class(input logic [2:0] stat);
      case (stat)
         ADIv5_STAT_OK:   return STAT_CLS_OK;
         ADIv5_STAT_WAIT: return STAT_CLS_WAIT;
         default:         return STAT_CLS_FAULT;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/adiv5_wait_retry_if.sv
// ============================================================================
// adiv5_wait_retry_if : WRDATA/WREN/WRFULL + RDDATA/RDEN/RDEMPTY FIFO port
// Revision 1.0
// ============================================================================
`default_nettype none

interface adiv5_wait_retry_if;
   import adiv5_wait_retry_pkg::*;

   logic [ADIv5_CMD_WIDTH-1:0]  wrdata;
   logic                        wren;
   logic                        wrfull;
   logic [ADIv5_RESP_WIDTH-1:0] rddata;
   logic                        rden;
   logic                        rdempty;

   modport slave  (input  wrdata, wren, rden,
                   output wrfull, rddata, rdempty);

   modport master (output wrdata, wren, rden,
                   input  wrfull, rddata, rdempty);
endinterface

`default_nettype wire

// File: rtl/adiv5_wait_retry_fifo.sv
// ============================================================================
// adiv5_sync_fifo : single-clock FIFO, registered read, separate peek/pop
// Revision 1.0
// ============================================================================
`default_nettype none

module adiv5_sync_fifo #(
   parameter int AW = 2,
   parameter int DW = 8
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   input  wire logic          flush,
   input  wire logic          wr,
   input  wire logic [DW-1:0] wdata,
   input  wire logic          rd,
   input  wire logic          pop,
   output      logic [DW-1:0] rdata,
   output      logic          full,
   output      logic          empty
);

   localparam int             DEPTH    = 1 << AW;
   localparam logic [AW:0]    FULL_CNT = DEPTH[AW:0];

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW:0]   count;
   logic          wr_ok;
   logic          pop_ok;

   assign full   = (count == FULL_CNT);
   assign empty  = (count == '0);
   // A full FIFO drops the write even if a pop frees a slot this cycle.
   assign wr_ok  = wr && !full && !flush;
   assign pop_ok = pop && !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         rdata <= '0;
      end else begin
         if (rd && !empty) begin
            rdata <= mem[rptr];
         end
         if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
         end else begin
            if (wr_ok) begin
               wptr <= wptr + AW'(1);
            end
            if (pop_ok) begin
               rptr <= rptr + AW'(1);
            end
            count <= count + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, pop_ok};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wptr] <= wdata;
      end
   end

endmodule

`default_nettype wire

// File: rtl/adiv5_wait_retry.sv
// ============================================================================
// adiv5_wait_retry : WAIT re-issue with backoff and sticky FAULT/TIMEOUT
// Revision 1.0
// ============================================================================
`default_nettype none

module adiv5_wait_retry
   import adiv5_wait_retry_pkg::*;
#(
   parameter int AW        = 2,
   parameter int MAX_RETRY = 15,
   parameter int BACKOFF   = 8
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   adiv5_wait_retry_if.slave  up,
   adiv5_wait_retry_if.master mux,
   input  wire logic         abort,
   input  wire logic         clr_sticky,
   output      logic [1:0]   sticky,
   output      logic [3:0]   last_retry
);

   localparam int BCW = $clog2(BACKOFF) + 1;

   retry_state_t                state;
   logic [3:0]                  retry;
   logic [BCW-1:0]              backoff_cnt;
   logic                        head_flushed;

   logic                        cmd_empty;
   logic                        cmd_rd;
   logic                        cmd_pop;
   logic [ADIv5_CMD_WIDTH-1:0]  cmd_head;
   logic                        resp_full;
   logic                        resp_wr;
   logic [ADIv5_RESP_WIDTH-1:0] resp_wdata;

   logic                        start;
   logic                        bypass;
   logic                        cap_wait;
   logic                        complete;
   stat_class_t                 cls;

   always_comb begin
      start      = (state == ST_IDLE) && !cmd_empty && !resp_full;
      bypass     = start && (sticky != 2'b00);
      cls        = stat_class(mux.rddata[2:0]);
      cap_wait   = (state == ST_CAPTURE) && (cls == STAT_CLS_WAIT) &&
                   (retry < 4'(MAX_RETRY));
      complete   = (state == ST_CAPTURE) && !cap_wait;
      cmd_rd     = start && !bypass;
      // The in-flight head is already gone if ABORT flushed the FIFO under it.
      cmd_pop    = bypass || (complete && !head_flushed);
      resp_wr    = bypass || complete;
      resp_wdata = bypass ? {32'h0, ADIv5_STAT_FAULT} : mux.rddata;
   end

   assign mux.wren   = (state == ST_ISSUE) && !mux.wrfull;
   assign mux.rden   = (state == ST_WAIT_RESP) && !mux.rdempty;
   assign mux.wrdata = cmd_head;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         retry       <= '0;
         backoff_cnt <= '0;
         last_retry  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_rd) begin
                  state <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (mux.wren) begin
                  state <= ST_WAIT_RESP;
               end
            end
            ST_WAIT_RESP: begin
               if (mux.rden) begin
                  state <= ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               if (cap_wait) begin
                  retry       <= retry + 4'd1;
                  backoff_cnt <= '0;
                  state       <= ST_BACKOFF;
               end else begin
                  last_retry <= retry;
                  retry      <= '0;
                  state      <= ST_IDLE;
               end
            end
            ST_BACKOFF: begin
               if (backoff_cnt == BCW'(BACKOFF - 1)) begin
                  state <= ST_ISSUE;
               end else begin
                  backoff_cnt <= backoff_cnt + BCW'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_flushed <= 1'b0;
         sticky       <= 2'b00;
      end else begin
         if (complete) begin
            head_flushed <= 1'b0;
         end else if (abort && ((state != ST_IDLE) || cmd_rd)) begin
            head_flushed <= 1'b1;
         end

         if (clr_sticky) begin
            sticky <= 2'b00;
         end else if (complete) begin
            if (cls == STAT_CLS_WAIT) begin
               sticky[1] <= 1'b1;
            end
            if (cls == STAT_CLS_FAULT) begin
               sticky[0] <= 1'b1;
            end
         end
      end
   end

   adiv5_sync_fifo #(
      .AW (AW),
      .DW (ADIv5_CMD_WIDTH)
   ) u_cmd_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (abort),
      .wr    (up.wren),
      .wdata (up.wrdata),
      .rd    (cmd_rd),
      .pop   (cmd_pop),
      .rdata (cmd_head),
      .full  (up.wrfull),
      .empty (cmd_empty)
   );

   adiv5_sync_fifo #(
      .AW (AW),
      .DW (ADIv5_RESP_WIDTH)
   ) u_resp_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (1'b0),
      .wr    (resp_wr),
      .wdata (resp_wdata),
      .rd    (up.rden),
      .pop   (up.rden),
      .rdata (up.rddata),
      .full  (resp_full),
      .empty (up.rdempty)
   );

endmodule

`default_nettype wire
